// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the pipeline hazard detector.
//   - RV32I opcode constants, also used by the ID-stage control decoder
//   - slot_t: one shadow pipeline slot {valid, rd, regwrite, memread}
//   - opcode-class helpers reads_rs1 / reads_rs2 / writes_rd / is_load
package hazard_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } slot_t;

  function automatic logic reads_rs1(input logic [6:0] opc);
    return (opc == OPC_R) || (opc == OPC_I) || (opc == OPC_LOAD) ||
           (opc == OPC_STORE) || (opc == OPC_BRANCH);
  endfunction

  function automatic logic reads_rs2(input logic [6:0] opc);
    return (opc == OPC_R) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
  endfunction

  function automatic logic writes_rd(input logic [6:0] opc);
    return (opc == OPC_R) || (opc == OPC_I) || (opc == OPC_LOAD);
  endfunction

  function automatic logic is_load(input logic [6:0] opc);
    return opc == OPC_LOAD;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// hazard_match: combinational compare of one shadow slot against the
// source registers of the instruction in ID.
//   REQ_MEMREAD : when 1, only a load in the slot can match (load-use)
//   slot_i      : shadow slot under test
//   rs1_i/rs2_i : ID source register fields
//   use_rs1_i/use_rs2_i : the ID opcode actually reads that field
//   hit_o       : slot produces a register the ID instruction needs
module hazard_match
  import hazard_pkg::*;
#(
  parameter bit REQ_MEMREAD = 1'b0
) (
  input  slot_t      slot_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic       use_rs1_i,
  input  logic       use_rs2_i,
  output logic       hit_o
);

  logic producer;
  logic src_hit;

  // x0 is hardwired zero, so a write to it never creates a dependency
  assign producer = slot_i.valid && slot_i.regwrite && (slot_i.rd != 5'd0) &&
                    (!REQ_MEMREAD || slot_i.memread);
  assign src_hit  = (use_rs1_i && (slot_i.rd == rs1_i)) ||
                    (use_rs2_i && (slot_i.rd == rs2_i));
  assign hit_o    = producer && src_hit;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: load-use / RAW stall and branch flush control for the
// 5-stage core, with stall and flush cycle counters.
//   Macro HAZARD_FORWARDING_EN: defined -> only a load in EX stalls;
//   undefined -> any register writer in EX or MEM stalls.
// Ports:
//   clk, reset (async, active high)
//   id_valid, id_opcode, id_rs1, id_rs2, id_rd : instruction in ID
//   ex_branch_taken : branch in EX resolved taken
//   stall, pc_write, ifid_write : stall control (combinational)
//   ifid_flush, idex_flush      : branch flush (combinational)
//   stall_cycles, flush_cycles  : wrapping performance counters
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             ex_branch_taken,
  output logic             stall,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
);

`ifdef HAZARD_FORWARDING_EN
  localparam int NCHK        = 1;
  localparam bit REQ_MEMREAD = 1'b1;
`else
  localparam int NCHK        = 2;
  localparam bit REQ_MEMREAD = 1'b0;
`endif

  slot_t ex_q, mem_q, wb_q, ex_d;
  slot_t chk_slot [NCHK];
  logic [NCHK-1:0] hit;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic use_rs1, use_rs2;

  assign use_rs1 = reads_rs1(id_opcode);
  assign use_rs2 = reads_rs2(id_opcode);

  // checked slots, youngest first: EX, then MEM when not forwarding
  assign chk_slot[0] = ex_q;
  if (NCHK > 1) begin : g_mem_chk
    assign chk_slot[1] = mem_q;
  end

  for (genvar g = 0; g < NCHK; g++) begin : g_match
    hazard_match #(.REQ_MEMREAD(REQ_MEMREAD)) u_match (
      .slot_i    (chk_slot[g]),
      .rs1_i     (id_rs1),
      .rs2_i     (id_rs2),
      .use_rs1_i (use_rs1),
      .use_rs2_i (use_rs2),
      .hit_o     (hit[g])
    );
  end

  // a taken branch squashes ID, so it overrides any stall
  assign stall      = id_valid && !ex_branch_taken && (|hit);
  assign pc_write   = !stall;
  assign ifid_write = !stall;
  assign ifid_flush = ex_branch_taken;
  assign idex_flush = ex_branch_taken;

  always_comb begin
    ex_d = '0;
    if (id_valid && !stall && !ex_branch_taken) begin
      ex_d.valid    = 1'b1;
      ex_d.rd       = id_rd;
      ex_d.regwrite = writes_rd(id_opcode);
      ex_d.memread  = is_load(id_opcode);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= ex_d;
      if (stall)      stall_cnt_q <= stall_cnt_q + 1'b1;
      if (ifid_flush) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_cycles = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;
  import hazard_pkg::*;

`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             id_valid;
  logic [6:0]       id_opcode;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic             ex_branch_taken;
  logic             stall, pc_write, ifid_write, ifid_flush, idex_flush;
  logic [CNT_W-1:0] stall_cycles, flush_cycles;

  int checks = 0;
  int errors = 0;

  hazard_unit #(.CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_opcode       (id_opcode),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rd           (id_rd),
    .ex_branch_taken (ex_branch_taken),
    .stall           (stall),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .stall_cycles    (stall_cycles),
    .flush_cycles    (flush_cycles)
  );

  always #5 clk = ~clk;

  // stimulus only: place one instruction in ID
  task automatic drive(input logic v, input logic [6:0] opc, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    id_valid  = v;
    id_opcode = opc;
    id_rd     = rd;
    id_rs1    = rs1;
    id_rs2    = rs2;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    ex_branch_taken = 1'b0;
    repeat (3) next_cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ex_branch_taken = 1'b0;
    drive(1'b1, OPC_R, 5'd6, 5'd5, 5'd2);
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin errors++; $display("FAIL reset_wr_en got=%b%b exp=11", pc_write, ifid_write); end
    checks++; if (ifid_flush !== 1'b0 || idex_flush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b%b exp=00", ifid_flush, idex_flush); end
    checks++; if (stall_cycles !== '0 || flush_cycles !== '0) begin errors++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cycles, flush_cycles); end
    next_cycle();
    reset = 1'b0;
    #1;
    // slots invalid: a consumer in ID must not stall
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_slots_invalid got=%b exp=0", stall); end
    next_cycle();
    checks++; if (stall_cycles !== '0) begin errors++; $display("FAIL reset_post_cnt got=%0d exp=0", stall_cycles); end
  endtask

  // ld x5,0(x1) ; add x6,x5,x2
  task automatic test_load_use();
    logic [CNT_W-1:0] s0;
    int nexp;
    logic e;
    drain();
    s0 = stall_cycles;
    nexp = FWD ? 1 : 2;
    drive(1'b1, OPC_LOAD, 5'd5, 5'd1, 5'd0);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_producer got=%b exp=0", stall); end
    next_cycle();
    drive(1'b1, OPC_R, 5'd6, 5'd5, 5'd2);
    for (int c = 0; c < 3; c++) begin
      #1;
      e = (c < nexp);
      checks++; if (stall !== e) begin errors++; $display("FAIL lu_stall_c%0d got=%b exp=%b", c, stall, e); end
      checks++; if (pc_write !== !e || ifid_write !== !e) begin errors++; $display("FAIL lu_wr_en_c%0d got=%b%b exp=%b%b", c, pc_write, ifid_write, !e, !e); end
      next_cycle();
    end
    checks++; if (stall_cycles !== s0 + CNT_W'(nexp)) begin errors++; $display("FAIL lu_stall_cycles got=%0d exp=%0d", stall_cycles, s0 + CNT_W'(nexp)); end
  endtask

  // ALU producer in EX (no stall with forwarding) and in MEM
  task automatic test_back_to_back();
    logic e;
    int nexp;
    drain();
    // add x7,x1,x2 ; sub x12,x7,x3
    drive(1'b1, OPC_R, 5'd7, 5'd1, 5'd2);
    next_cycle();
    drive(1'b1, OPC_R, 5'd12, 5'd7, 5'd3);
    nexp = FWD ? 0 : 2;
    for (int c = 0; c < 3; c++) begin
      #1;
      e = (c < nexp);
      checks++; if (stall !== e) begin errors++; $display("FAIL raw_ex_c%0d got=%b exp=%b", c, stall, e); end
      next_cycle();
    end
    drain();
    // add x7,x1,x2 ; addi x10,x11,1 ; sub x12,x3,x7  (producer in MEM)
    drive(1'b1, OPC_R, 5'd7, 5'd1, 5'd2);
    next_cycle();
    drive(1'b1, OPC_I, 5'd10, 5'd11, 5'd7);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_i_ignores_rs2 got=%b exp=0", stall); end
    next_cycle();
    drive(1'b1, OPC_R, 5'd12, 5'd3, 5'd7);
    nexp = FWD ? 0 : 1;
    for (int c = 0; c < 2; c++) begin
      #1;
      e = (c < nexp);
      checks++; if (stall !== e) begin errors++; $display("FAIL raw_mem_c%0d got=%b exp=%b", c, stall, e); end
      next_cycle();
    end
    drain();
    // ld x8 ; sw x8,0(x1): store reads rs2
    drive(1'b1, OPC_LOAD, 5'd8, 5'd1, 5'd0);
    next_cycle();
    drive(1'b1, OPC_STORE, 5'd9, 5'd1, 5'd8);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL store_rs2_stall got=%b exp=1", stall); end
    next_cycle();
    drain();
    // store's rd field is immediate bits, not a write: no stall on x9
    drive(1'b1, OPC_STORE, 5'd9, 5'd1, 5'd2);
    next_cycle();
    drive(1'b1, OPC_R, 5'd4, 5'd9, 5'd9);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL store_no_write got=%b exp=0", stall); end
    next_cycle();
    drain();
    // id_valid low never stalls
    drive(1'b1, OPC_LOAD, 5'd5, 5'd1, 5'd0);
    next_cycle();
    drive(1'b0, OPC_R, 5'd6, 5'd5, 5'd2);
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL invalid_id got=%b exp=0", stall); end
    next_cycle();
  endtask

  // addi x0,x0,1 ; add x3,x0,x0
  task automatic test_x0();
    drain();
    drive(1'b1, OPC_I, 5'd0, 5'd0, 5'd0);
    next_cycle();
    drive(1'b1, OPC_R, 5'd3, 5'd0, 5'd0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL x0_c%0d got=%b exp=0", c, stall); end
      next_cycle();
    end
  endtask

  task automatic test_branch_flush();
    logic [CNT_W-1:0] f0, s0;
    drain();
    f0 = flush_cycles;
    s0 = stall_cycles;
    drive(1'b1, OPC_LOAD, 5'd5, 5'd1, 5'd0);
    next_cycle();
    drive(1'b1, OPC_R, 5'd6, 5'd5, 5'd2);
    ex_branch_taken = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL br_stall got=%b exp=0", stall); end
    checks++; if (ifid_flush !== 1'b1 || idex_flush !== 1'b1) begin errors++; $display("FAIL br_flush got=%b%b exp=11", ifid_flush, idex_flush); end
    checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL br_pc_write got=%b exp=1", pc_write); end
    next_cycle();
    ex_branch_taken = 1'b0;
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    #1;
    checks++; if (flush_cycles !== f0 + 1'b1) begin errors++; $display("FAIL br_flush_cycles got=%0d exp=%0d", flush_cycles, f0 + 1'b1); end
    checks++; if (stall_cycles !== s0) begin errors++; $display("FAIL br_stall_cycles got=%0d exp=%0d", stall_cycles, s0); end
    checks++; if (ifid_flush !== 1'b0) begin errors++; $display("FAIL br_flush_clear got=%b exp=0", ifid_flush); end
    next_cycle();
  endtask

  task automatic test_reset_mid_stall();
    drain();
    drive(1'b1, OPC_LOAD, 5'd5, 5'd1, 5'd0);
    next_cycle();
    drive(1'b1, OPC_R, 5'd6, 5'd5, 5'd2);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mid_pre_stall got=%b exp=1", stall); end
    // pulse reset between edges: only an asynchronous clear takes effect
    #1 reset = 1'b1;
    #1;
    checks++; if (stall !== 1'b0 || pc_write !== 1'b1) begin errors++; $display("FAIL mid_async_clear got=%b%b exp=01", stall, pc_write); end
    checks++; if (stall_cycles !== '0 || flush_cycles !== '0) begin errors++; $display("FAIL mid_counters got=%0d/%0d exp=0/0", stall_cycles, flush_cycles); end
    #1 reset = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mid_post_release got=%b exp=0", stall); end
    next_cycle();
    #1;
    checks++; if (stall !== 1'b0 || stall_cycles !== '0) begin errors++; $display("FAIL mid_next_inst got=%b/%0d exp=0/0", stall, stall_cycles); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_back_to_back();
    test_x0();
    test_branch_flush();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard detector for the 5-stage RISC-V core; it produces the `stall` input consumed by the ID-stage control decoder. It keeps a registered shadow of the EX, MEM and WB stage destination registers. From that shadow it decides load-use or RAW stalls, drives the PC and IF/ID write enables, and issues the flushes for a taken branch. It also counts stall and flush cycles for performance monitoring.

## Interface
- `CNT_W`, default 32: width of the stall and flush counters.
- `clk` input 1: core clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `id_valid` input 1: the IF/ID register holds a real instruction.
- `id_opcode` input 7: opcode of the instruction in ID.
- `id_rs1` input 5: rs1 field of the instruction in ID.
- `id_rs2` input 5: rs2 field of the instruction in ID.
- `id_rd` input 5: rd field of the instruction in ID.
- `ex_branch_taken` input 1: the branch in EX resolved taken this cycle.
- `stall` output 1: forces the control decoder to emit a bubble into ID/EX.
- `pc_write` output 1: PC update enable; equals `!stall`.
- `ifid_write` output 1: IF/ID update enable; equals `!stall`.
- `ifid_flush` output 1: zero IF/ID on the next edge.
- `idex_flush` output 1: zero ID/EX on the next edge.
- `stall_cycles` output `CNT_W`: count of cycles with `stall`=1; wraps.
- `flush_cycles` output `CNT_W`: count of cycles with `ifid_flush`=1; wraps.

## Operation
- Opcode classes:
  - Register read: rs1 is read by R, I-ALU, load, store and branch; rs2 is read by R, store and branch.
  - Register write: R, I-ALU and load write rd.
  - Memory read: load only.
  - All other opcodes read and write nothing.
- Shadow slots EX, MEM and WB. Each slot holds {valid, rd, regwrite, memread}.
- Every edge, WB takes MEM and MEM takes EX.
- EX takes the ID instruction's info if `id_valid`, `!stall` and `!ex_branch_taken`. Otherwise EX takes a bubble (valid=0).
- Hazard match: a slot is valid, has regwrite=1, has rd≠0, and rd equals a source register the ID instruction reads.
- `stall` = `id_valid` & `!ex_branch_taken` & a hazard match, as defined in Configuration.
- Taken branch: `ex_branch_taken`=1 drives `ifid_flush`=1 and `idex_flush`=1 and forces `stall`=0. Flush has priority over stall.
- Counters increment on the edge after the qualifying cycle and wrap to 0 at 2^CNT_W.

## Timing
- `stall`, `pc_write`, `ifid_write` and both flush outputs are combinational from the inputs and the slots, valid in the same cycle.
- Slot and counter updates take effect on the following edge.
- Reset values: all slots invalid, `stall`=0, `pc_write`=1, `ifid_write`=1, both flushes 0, both counters 0.
- Reset asserted mid-stall clears everything asynchronously. The first cycle after release has no stall.
- Stall length, because the register file is write-first:
  - Load-use with forwarding: 1 cycle.
  - RAW without forwarding, producer in EX: 2 cycles.
  - RAW without forwarding, producer in MEM: 1 cycle.
- A source register of x0 never stalls.

## Configuration
- `HAZARD_FORWARDING_EN`
  - Defined: only the EX slot is checked, and a match requires memread=1 (load-use).
  - Undefined: the EX and MEM slots are checked for any regwrite match. The WB slot is never checked.

## Structure
- Shared package `hazard_pkg`:
  - Opcode constants `OPC_R`, `OPC_I`, `OPC_LOAD`, `OPC_STORE` and `OPC_BRANCH`, shared with the control decoder.
  - The slot struct typedef.
  - Functions `reads_rs1`, `reads_rs2`, `writes_rd` and `is_load`.
- One sub-module, `hazard_match`: a combinational comparison of one slot against rs1/rs2 and the use flags, instantiated once per checked slot.

## Test plan
- Reset with `reset`=1 → `stall`=0, `pc_write`=1, counters 0, all slots invalid.
- `ld x5,0(x1)`, then `add x6,x5,x2` with forwarding → `stall`=1 for exactly 1 cycle, `stall_cycles`=1, then `add` proceeds.
- Same pair without forwarding → `stall` held for 2 cycles.
- `addi x0,x0,1`, then `add x3,x0,x0`, either mode → `stall` never asserted.
- `ex_branch_taken`=1 while ID holds a load-use consumer → `stall`=0, `ifid_flush`=1, `idex_flush`=1, `flush_cycles` increments by 1.
- `reset` asserted during a 2-cycle stall → outputs return to reset values immediately; the next instruction sees no stall.
